dcpu16_marb: RTL

DCPU16_MARB -- requirements
Module: dcpu16_marb

---
 rtl/dcpu16_pkg.sv | 14 +
 rtl/dcpu16_marb_pick.sv | 47 ++++
 rtl/dcpu16_marb.sv | 99 +++++++++
 3 files changed

// File: rtl/dcpu16_pkg.sv
// Shared types and default widths for the DCPU16 memory arbiter.
package dcpu16_pkg;

    localparam int unsigned DefAw = 16;
    localparam int unsigned DefDw = 16;

    typedef enum logic [1:0] {StIdle, StBusy, StAck} marb_state_e;

    // Grant index width, never narrower than one bit.
    function automatic int unsigned gnt_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/dcpu16_marb_pick.sv
// Combinational winner selection among requesting channels.
// DCPU16_MARB_RR_EN selects round-robin from ptr+1; otherwise lowest index wins.
module dcpu16_marb_pick
    import dcpu16_pkg::*;
#(
    parameter int unsigned CH = 2,
    parameter int unsigned GW = 1
) (
    input  logic [CH-1:0] stb,
    input  logic [GW-1:0] ptr,
    output logic          any,
    output logic [GW-1:0] gnt
);

    logic [GW-1:0] idx;

    assign any = |stb;

`ifdef DCPU16_MARB_RR_EN
    // Scan backwards so the candidate closest after ptr is the last one written.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = int'(CH); i >= 1; i--) begin
            idx = GW'((int'(ptr) + i) % int'(CH));
            if (stb[idx]) begin
                gnt = idx;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            idx = GW'(i);
            if (stb[idx]) begin
                gnt = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/dcpu16_marb.sv
// Memory arbiter: CH channels share one memory port with one transfer in flight.
// Define DCPU16_MARB_RR_EN for round-robin arbitration; default is fixed priority.
module dcpu16_marb
    import dcpu16_pkg::*;
#(
    parameter int unsigned CH = 2,
    parameter int unsigned AW = DefAw,
    parameter int unsigned DW = DefDw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*AW-1:0] c_adr,
    input  logic [CH-1:0]    c_stb,
    input  logic [CH-1:0]    c_wre,
    input  logic [CH*DW-1:0] c_dto,
    output logic [CH-1:0]    c_ack,
    output logic [DW-1:0]    c_dti,
    output logic [AW-1:0]    m_adr,
    output logic             m_wre,
    output logic [DW-1:0]    m_dto,
    output logic             m_stb,
    input  logic [DW-1:0]    m_dti,
    input  logic             m_ack,
    output logic             ena
);

    localparam int unsigned GW = gnt_width(CH);

    marb_state_e   state_q, state_d;
    logic [GW-1:0] gnt_q;
    logic [GW-1:0] ptr_q;
    logic [GW-1:0] pick_gnt;
    logic          pick_any;

    dcpu16_marb_pick #(
        .CH(CH),
        .GW(GW)
    ) u_pick (
        .stb(c_stb),
        .ptr(ptr_q),
        .any(pick_any),
        .gnt(pick_gnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StBusy;
            StBusy:  if (m_ack) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= GW'(CH - 1);
            m_stb   <= 1'b0;
            m_wre   <= 1'b0;
            m_adr   <= '0;
            m_dto   <= '0;
            c_ack   <= '0;
            c_dti   <= '0;
        end else begin
            state_q <= state_d;
            c_ack   <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        gnt_q <= pick_gnt;
                        ptr_q <= pick_gnt;
                        m_adr <= c_adr[32'(pick_gnt)*AW +: AW];
                        m_dto <= c_dto[32'(pick_gnt)*DW +: DW];
                        m_wre <= c_wre[pick_gnt];
                        m_stb <= 1'b1;
                    end
                end
                StBusy: begin
                    // Completion does not depend on the requester still holding c_stb.
                    if (m_ack) begin
                        m_stb        <= 1'b0;
                        c_ack[gnt_q] <= 1'b1;
                        if (!m_wre) begin
                            c_dti <= m_dti;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ena = &(~c_stb | c_ack);
    end

endmodule
